// File: rtl/dm_store_align.sv
// Store aligner with a 2-entry write buffer: converts byte-addressed sw/sh/sb requests into
// word-aligned, lane-replicated writes. Optional misaligned-store trap: DM_STORE_MISALIGN_CHK_EN.
module dm_store_align #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_sel,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        exc_ades,
    output logic [31:0] exc_addr
);

    localparam logic [1:0] FULL = 2'(DEPTH);
    localparam logic [1:0] SEL_SW = 2'b00;
    localparam logic [1:0] SEL_SH = 2'b01;
    localparam logic [1:0] SEL_SB = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    logic [31:0] addr_mem [0:1];
    logic [31:0] data_mem [0:1];
    logic [3:0]  be_mem   [0:1];

    logic [1:0]  count_reg, count_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic [31:0] head_addr_reg, head_addr_next;
    logic [31:0] head_data_reg, head_data_next;
    logic [3:0]  head_be_reg, head_be_next;

    logic [31:0] conv_addr;
    logic [31:0] conv_wdata;
    logic [3:0]  conv_be;
    logic        misaligned;
    logic        accept;
    logic        enq;
    logic        deq;
    logic        head_from_new;

    assign st_ready  = (count_reg != FULL);
    assign mem_valid = (count_reg != 2'd0);
    assign mem_addr  = head_addr_reg;
    assign mem_wdata = head_data_reg;
    assign mem_be    = head_be_reg;

    assign accept    = st_valid && st_ready;
    assign enq       = accept && !misaligned && (st_sel != SEL_RSV);
    assign deq       = mem_valid && mem_ready;
    assign conv_addr = {st_addr[31:2], 2'b00};

`ifdef DM_STORE_MISALIGN_CHK_EN
    assign misaligned = ((st_sel == SEL_SW) && (st_addr[1:0] != 2'b00)) ||
                        ((st_sel == SEL_SH) && st_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Each byte lane picks its source: byte 0 for sb, the matching half-word byte for sh.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign conv_wdata[8*gi+7:8*gi] =
                (st_sel == SEL_SB) ? st_data[7:0] :
                (st_sel == SEL_SH) ? st_data[8*(gi%2)+7:8*(gi%2)] :
                                     st_data[8*gi+7:8*gi];
        end
    endgenerate

    always_comb begin
        conv_be = 4'b0000;
        case (st_sel)
            SEL_SW:  conv_be = 4'b1111;
            SEL_SH:  conv_be = st_addr[1] ? 4'b1100 : 4'b0011;
            SEL_SB:  conv_be = 4'b0001 << st_addr[1:0];
            default: conv_be = 4'b0000;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        wr_ptr_next = wr_ptr_reg ^ enq;
        rd_ptr_next = rd_ptr_reg ^ deq;
        // The next head is the entry being written now when it lands at the new read pointer.
        head_from_new  = enq && (wr_ptr_reg == rd_ptr_next);
        head_addr_next = head_from_new ? conv_addr  : addr_mem[rd_ptr_next];
        head_data_next = head_from_new ? conv_wdata : data_mem[rd_ptr_next];
        head_be_next   = head_from_new ? conv_be    : be_mem[rd_ptr_next];
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_reg] <= conv_addr;
            data_mem[wr_ptr_reg] <= conv_wdata;
            be_mem[wr_ptr_reg]   <= conv_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            head_addr_reg <= 32'd0;
            head_data_reg <= 32'd0;
            head_be_reg   <= 4'b0000;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            // Empty buffer keeps the last head values on the outputs.
            if (count_next != 2'd0) begin
                head_addr_reg <= head_addr_next;
                head_data_reg <= head_data_next;
                head_be_reg   <= head_be_next;
            end
        end
    end

`ifdef DM_STORE_MISALIGN_CHK_EN
    logic        exc_ades_reg;
    logic [31:0] exc_addr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_ades_reg <= 1'b0;
            exc_addr_reg <= 32'd0;
        end else begin
            exc_ades_reg <= accept && misaligned;
            if (accept && misaligned) begin
                exc_addr_reg <= st_addr;
            end
        end
    end

    assign exc_ades = exc_ades_reg;
    assign exc_addr = exc_addr_reg;
`else
    assign exc_ades = 1'b0;
    assign exc_addr = 32'd0;
`endif

endmodule

// File: tb/tb_dm_store_align.sv
// Directed self-checking bench for dm_store_align; follows DM_STORE_MISALIGN_CHK_EN if defined.
module tb_dm_store_align;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_sel;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        exc_ades;
    logic [31:0] exc_addr;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dm_store_align dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_sel(st_sel),
        .st_addr(st_addr), .st_data(st_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .exc_ades(exc_ades), .exc_addr(exc_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_sel   = sel;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        vectors++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_st_ready: got %b expected 1", st_ready); end
        vectors++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        vectors++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin errors++;
            $display("FAIL reset_head: got addr=%h wdata=%h be=%b expected all zero", mem_addr, mem_wdata, mem_be); end
        vectors++; if ({exc_ades, exc_addr} !== 33'h0) begin errors++;
            $display("FAIL reset_exc: got ades=%b addr=%h expected 0/0", exc_ades, exc_addr); end
        $display("reset: st_ready=%b mem_valid=%b", st_ready, mem_valid);
    endtask

    // One store with mem_ready high: visible the next cycle, gone (outputs held) the cycle after.
    task automatic test_single(input string name, input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_data);
        mem_ready = 1'b1;
        drive(1'b1, sel, a, d);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== exp_addr || mem_be !== exp_be || mem_wdata !== exp_data) begin
            errors++;
            $display("FAIL %s: got v=%b addr=%h be=%b wdata=%h expected v=1 addr=%h be=%b wdata=%h",
                     name, mem_valid, mem_addr, mem_be, mem_wdata, exp_addr, exp_be, exp_data);
        end
        $display("%s: addr=%h be=%b wdata=%h", name, mem_addr, mem_be, mem_wdata);
        tick();
        vectors++; if (mem_valid !== 1'b0 || mem_addr !== exp_addr || mem_be !== exp_be) begin errors++;
            $display("FAIL %s_drain_hold: got v=%b addr=%h be=%b expected v=0 addr=%h be=%b",
                     name, mem_valid, mem_addr, mem_be, exp_addr, exp_be); end
    endtask

    task automatic test_reserved();
        mem_ready = 1'b1;
        drive(1'b1, 2'b11, 32'h0000_0200, 32'h1111_1111);
        vectors++; if (st_ready !== 1'b1) begin errors++; $display("FAIL rsv_ready: got %b expected 1", st_ready); end
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (mem_valid !== 1'b0 || exc_ades !== 1'b0) begin errors++;
            $display("FAIL rsv_drop: got v=%b exc=%b expected 0/0", mem_valid, exc_ades); end
        $display("reserved: mem_valid=%b exc_ades=%b", mem_valid, exc_ades);
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0100, 32'h0000_0001);
        tick();
        drive(1'b1, 2'b00, 32'h0000_0104, 32'h0000_0002);
        tick();
        drive(1'b1, 2'b00, 32'h0000_0108, 32'h0000_0003);
        vectors++; if (st_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got st_ready=%b expected 0", st_ready); end
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h1) begin errors++;
            $display("FAIL b2b_head1: got v=%b addr=%h wdata=%h expected 1/00000100/00000001", mem_valid, mem_addr, mem_wdata); end
        tick();
        vectors++; if (st_ready !== 1'b0 || mem_addr !== 32'h100 || mem_wdata !== 32'h1 || mem_be !== 4'hF) begin errors++;
            $display("FAIL b2b_stall: got rdy=%b addr=%h wdata=%h be=%b expected 0/00000100/00000001/1111",
                     st_ready, mem_addr, mem_wdata, mem_be); end
        mem_ready = 1'b1;
        tick();
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'h2 || st_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_head2: got v=%b addr=%h wdata=%h rdy=%b expected 1/00000104/00000002/1",
                     mem_valid, mem_addr, mem_wdata, st_ready); end
        $display("b2b: second head addr=%h", mem_addr);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h108 || mem_wdata !== 32'h3) begin errors++;
            $display("FAIL b2b_head3: got v=%b addr=%h wdata=%h expected 1/00000108/00000003", mem_valid, mem_addr, mem_wdata); end
        $display("b2b: third head addr=%h", mem_addr);
        tick();
        vectors++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got v=%b expected 0", mem_valid); end
    endtask

    task automatic test_throughput();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b00, 32'h0000_0300 + 32'(4*i), 32'hA000_0000 + 32'(i));
            tick();
            vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0300 + 32'(4*i) || mem_wdata !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL tput_%0d: got v=%b addr=%h wdata=%h expected 1/%h/%h", i, mem_valid, mem_addr, mem_wdata,
                         32'h0000_0300 + 32'(4*i), 32'hA000_0000 + 32'(i));
            end
            $display("tput %0d: addr=%h wdata=%h", i, mem_addr, mem_wdata);
        end
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_misalign();
        mem_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_1002, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef DM_STORE_MISALIGN_CHK_EN
        vectors++; if (exc_ades !== 1'b1 || exc_addr !== 32'h1002 || mem_valid !== 1'b0) begin errors++;
            $display("FAIL ades_pulse: got exc=%b addr=%h v=%b expected 1/00001002/0", exc_ades, exc_addr, mem_valid); end
        $display("misalign sw: exc_ades=%b exc_addr=%h", exc_ades, exc_addr);
        tick();
        vectors++; if (exc_ades !== 1'b0 || exc_addr !== 32'h1002 || mem_valid !== 1'b0) begin errors++;
            $display("FAIL ades_end: got exc=%b addr=%h v=%b expected 0/00001002/0", exc_ades, exc_addr, mem_valid); end
        drive(1'b1, 2'b01, 32'h0000_0021, 32'h0000_7777);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (exc_ades !== 1'b1 || exc_addr !== 32'h21 || mem_valid !== 1'b0) begin errors++;
            $display("FAIL ades_sh: got exc=%b addr=%h v=%b expected 1/00000021/0", exc_ades, exc_addr, mem_valid); end
        $display("misalign sh: exc_ades=%b exc_addr=%h", exc_ades, exc_addr);
        tick();
`else
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h1000 || mem_be !== 4'hF || mem_wdata !== 32'hCAFE_F00D || exc_ades !== 1'b0) begin
            errors++;
            $display("FAIL nochk_sw: got v=%b addr=%h be=%b wdata=%h exc=%b expected 1/00001000/1111/cafef00d/0",
                     mem_valid, mem_addr, mem_be, mem_wdata, exc_ades);
        end
        $display("unchecked sw: addr=%h be=%b", mem_addr, mem_be);
        tick();
        drive(1'b1, 2'b01, 32'h0000_0023, 32'h0000_7777);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h20 || mem_be !== 4'b1100 || mem_wdata !== 32'h7777_7777) begin errors++;
            $display("FAIL nochk_sh: got v=%b addr=%h be=%b wdata=%h expected 1/00000020/1100/77777777",
                     mem_valid, mem_addr, mem_be, mem_wdata); end
        $display("unchecked sh: addr=%h be=%b", mem_addr, mem_be);
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0500, 32'h5);
        tick();
        drive(1'b1, 2'b00, 32'h0000_0504, 32'h6);
        tick();
        reset = 1'b1;
        drive(1'b1, 2'b10, 32'h0000_0508, 32'h7);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (mem_valid !== 1'b0 || st_ready !== 1'b1 || mem_addr !== 32'h0) begin errors++;
            $display("FAIL rst_mid: got v=%b rdy=%b addr=%h expected 0/1/00000000", mem_valid, st_ready, mem_addr); end
        $display("reset mid: mem_valid=%b st_ready=%b", mem_valid, st_ready);
        mem_ready = 1'b1;
        drive(1'b1, 2'b10, 32'h0000_0041, 32'h0000_005A);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        vectors++; if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A_5A5A) begin errors++;
            $display("FAIL rst_sb: got v=%b addr=%h be=%b wdata=%h expected 1/00000040/0010/5a5a5a5a",
                     mem_valid, mem_addr, mem_be, mem_wdata); end
        $display("post-reset sb: addr=%h be=%b", mem_addr, mem_be);
        tick();
        vectors++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_alone: got v=%b expected 0", mem_valid); end
    endtask

    initial begin
        test_reset();
        test_single("sw_1004", 2'b00, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF);
        test_single("sb_13",   2'b10, 32'h0000_0013, 32'h0000_00A5, 32'h0000_0010, 4'b1000, 32'hA5A5_A5A5);
        test_single("sb_11",   2'b10, 32'h0000_0011, 32'h1234_56C3, 32'h0000_0010, 4'b0010, 32'hC3C3_C3C3);
        test_single("sh_22",   2'b01, 32'h0000_0022, 32'h1234_BEEF, 32'h0000_0020, 4'b1100, 32'hBEEF_BEEF);
        test_single("sh_20",   2'b01, 32'h0000_0020, 32'hFFFF_0102, 32'h0000_0020, 4'b0011, 32'h0102_0102);
        test_reserved();
        test_back_to_back();
        test_throughput();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dm_store_align.md
# dm_store_align

Store-side counterpart to the load-data extender: takes store requests from the M stage and converts the byte address and store type into a word-aligned address, replicated write data and a 4-bit byte enable. Converted requests go into a 2-entry write buffer that drains to the data memory / bridge over a valid/ready handshake. Misaligned stores are flagged as an address-error-on-store pulse and are never written.

## Interface
Parameters:
- `DEPTH`, 2 — write-buffer entries; fixed at 2, and the count register is 2 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  store request present.
- `st_ready`  out  1  request accepted this cycle when `st_valid && st_ready`.
- `st_sel`  in  2  store type: `00` sw, `01` sh, `10` sb, `11` reserved.
- `st_addr`  in  32  byte address.
- `st_data`  in  32  register data; low half or low byte is used for sh / sb.
- `mem_valid`  out  1  buffer head valid.
- `mem_ready`  in  1  memory accepts the head this cycle.
- `mem_addr`  out  32  head address with `[1:0]` forced to `00`.
- `mem_wdata`  out  32  head write data, lane-replicated.
- `mem_be`  out  4  head byte enables; bit i enables bits `[8i+7:8i]`.
- `exc_ades`  out  1  one-cycle misaligned-store pulse.
- `exc_addr`  out  32  byte address of the faulting store; held until the next fault.

## Operation
Conversion, applied when the request is accepted:
- sw: `be=1111`, `wdata=st_data`.
- sh: `be=0011` when `addr[1]=0`, `be=1100` when `addr[1]=1`; `wdata={st_data[15:0],st_data[15:0]}`.
- sb: `be=0001<<addr[1:0]`; `wdata={4{st_data[7:0]}}`.
- Misalignment: sw with `addr[1:0]!=00`, or sh with `addr[0]=1`. The request is accepted (handshake completes), nothing is enqueued, and `exc_ades` pulses.
- `st_sel=11`: accepted and dropped silently; no exception.

Write buffer:
- Circular, 2 entries, with read and write pointers and a count of 0..2.
- `st_ready = (count != 2)`. It depends only on registered state; there is no path from `mem_ready`.
- Enqueue fires on `st_valid && st_ready && aligned && st_sel != 11`.
- Dequeue fires on `mem_valid && mem_ready`.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This cannot occur at count 2 because `st_ready` is low.
- Count 0: `mem_valid=0`, and `mem_addr`, `mem_wdata`, `mem_be` hold their last values.
- Ordering is strict FIFO; no store merging.

## Timing
- Reset values: `st_ready=1`, `mem_valid=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0000`, `exc_ades=0`, `exc_addr=0`; count and pointers are 0.
- Reset mid-operation discards all buffered entries, including an entry being handshaked in that cycle.
- Latency: a request accepted at edge N is on the `mem_*` outputs with `mem_valid=1` after edge N when the buffer was empty, with no combinational bypass.
- Throughput: one store per cycle while `mem_ready` is held high.
- `exc_ades` is registered and is high for exactly the cycle after the faulting accept edge. `exc_addr` updates on that same edge.
- While `mem_valid=1 && mem_ready=0`, all head outputs stay stable.

## Configuration
- `DM_STORE_MISALIGN_CHK_EN` defined: misalignment is detected as described above.
- `DM_STORE_MISALIGN_CHK_EN` undefined:
  - No exception; `exc_ades` is tied to 0 and `exc_addr` to 0.
  - sw ignores `addr[1:0]`.
  - sh ignores `addr[0]`.
  - The store is enqueued normally.

## Test plan
- Reset, then sw to `0x0000_1004` with data `0xDEADBEEF` and `mem_ready=1` → next cycle `mem_valid=1`, `mem_addr=0x1004`, `mem_be=1111`, `mem_wdata=0xDEADBEEF`.
- sb to `0x13`, data `0x000000A5` → `mem_addr=0x10`, `mem_be=1000`, `mem_wdata=0xA5A5A5A5`.
- sh to `0x22`, data `0x1234BEEF` → `mem_be=1100`, `mem_wdata=0xBEEFBEEF`.
- `mem_ready=0`, three back-to-back sw → first two accepted, `st_ready=0` on the third. Raise `mem_ready` → drain order 1, 2, then the third is accepted.
- With the macro defined, sw to `0x1002` → `exc_ades=1` for one cycle, `exc_addr=0x1002`, `mem_valid` stays 0. Without the macro → store is written with `mem_addr=0x1000`, `be=1111`.
- Two entries buffered, assert `reset` for one cycle → `mem_valid=0` and `st_ready=1` the next cycle; a subsequent sb is delivered alone.
